// File: rtl/demux_8_deser.sv
// rtl/demux_8_deser.sv - 1:8 serial-to-parallel deserializer with valid/ready byte output
//
// Purpose:
//   Receive-side counterpart of the 8:1 bit-select mux tree. A slot counter
//   steers each accepted serial bit into one position of an assembly register.
//   When the frame completes, the byte moves into a one-deep output register
//   presented on a valid/ready port. The next byte assembles while the
//   previous one waits downstream. Only the final bit of a frame can stall.
//
// Parameters:
//   LSB_FIRST  1: stream bit k lands in out_data[k]; 0: it lands in out_data[7-k]
//
// Optional feature (macro DEMUX8_PARITY_EN):
//   When defined, a frame is 8 data bits followed by one even-parity bit.
//   sel widens to 4 bits and counts 0..8. The parity_err port is then present;
//   it is loaded together with out_data and is meaningful only while out_valid=1.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   in_valid    in   serial bit present
//   in_bit      in   serial data bit
//   in_ready    out  block accepts in_bit this cycle
//   sel         out  slot counter, i.e. stream index of the next bit
//   out_valid   out  assembled byte available
//   out_ready   in   downstream accepts the byte
//   out_data    out  assembled byte
//   parity_err  out  parity mismatch for the byte on out_data (DEMUX8_PARITY_EN only)

module demux_8_deser #(
  parameter int LSB_FIRST = 1,
`ifdef DEMUX8_PARITY_EN
  localparam int SEL_W     = 4,
  localparam int LAST_SLOT = 8
`else
  localparam int SEL_W     = 3,
  localparam int LAST_SLOT = 7
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data
`ifdef DEMUX8_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  // S_LAST mirrors sel==LAST_SLOT so the stall decision does not need a
  // wide compare on the counter every cycle.
  typedef enum logic {
    S_COLLECT,
    S_LAST
  } state_t;

  state_t     state;
  logic [7:0] asm_q;
  logic [7:0] asm_merged;
  logic [2:0] slot;
  logic       bit_acc;
  logic       byte_acc;
  logic       complete;

  // The last bit of a frame stalls only while the output register holds a
  // byte that is not draining this cycle.
  assign in_ready = !((state == S_LAST) && out_valid && !out_ready);

  assign bit_acc  = in_valid && in_ready;
  assign byte_acc = out_valid && out_ready;
  assign complete = bit_acc && (state == S_LAST);

  // Stream index to register position. In parity mode sel[3] is only set on
  // the parity slot, which never writes the assembly register.
  assign slot = (LSB_FIRST != 0) ? sel[2:0] : (3'd7 - sel[2:0]);

  // Assembly register with the incoming bit merged into its slot; this lets
  // the completing data bit reach out_data on the same edge it is accepted.
  always_comb begin
    asm_merged       = asm_q;
    asm_merged[slot] = in_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_COLLECT;
      sel       <= '0;
      asm_q     <= 8'h00;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
`ifdef DEMUX8_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (bit_acc) begin
        if (state == S_LAST) begin
          // Final bit of the frame: wrap the counter and publish the byte.
          state <= S_COLLECT;
          sel   <= '0;
`ifdef DEMUX8_PARITY_EN
          // The final bit is the parity bit; data is already complete.
          out_data   <= asm_q;
          parity_err <= (^asm_q) ^ in_bit;
`else
          asm_q    <= asm_merged;
          out_data <= asm_merged;
`endif
        end else begin
          asm_q <= asm_merged;
          sel   <= sel + SEL_W'(1);
          if (sel == SEL_W'(LAST_SLOT - 1)) begin
            state <= S_LAST;
          end
        end
      end

      // A completion wins over a drain on the same edge, so a byte every
      // frame time flows through with no bubble.
      if (complete) begin
        out_valid <= 1'b1;
      end else if (byte_acc) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux_8_deser.sv
// tb/tb_demux_8_deser.sv - directed and random bench for demux_8_deser, both bit orders

module tb_demux_8_deser;

`ifdef DEMUX8_PARITY_EN
  localparam int SW    = 4;
  localparam int FRAME = 9;
`else
  localparam int SW    = 3;
  localparam int FRAME = 8;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_bit;
  logic          out_ready;
  logic          rdy_l, rdy_m;
  logic          ov_l, ov_m;
  logic [SW-1:0] sel_l, sel_m;
  logic [7:0]    od_l, od_m;
`ifdef DEMUX8_PARITY_EN
  logic          pe_l, pe_m;
`endif

  always #5 clk = ~clk;

  demux_8_deser #(.LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(rdy_l), .sel(sel_l), .out_valid(ov_l), .out_ready(out_ready),
    .out_data(od_l)
`ifdef DEMUX8_PARITY_EN
    , .parity_err(pe_l)
`endif
  );

  demux_8_deser #(.LSB_FIRST(0)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(rdy_m), .sel(sel_m), .out_valid(ov_m), .out_ready(out_ready),
    .out_data(od_m)
`ifdef DEMUX8_PARITY_EN
    , .parity_err(pe_m)
`endif
  );

  // Reference model: bits of the current frame in stream order, plus the
  // last published byte for each bit order.
  int         m_sel;
  bit         m_ov;
  bit         m_known;
  logic [7:0] m_lsb, m_msb;
  bit         m_perr;
  bit         frame_bits [FRAME];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic publish();
    m_lsb  = 8'h00;
    m_msb  = 8'h00;
    m_perr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (frame_bits[k]) begin
        m_lsb = m_lsb | (8'h01 << k);
        m_msb = m_msb | (8'h80 >> k);
      end
    end
    for (int k = 0; k < FRAME; k++) m_perr = m_perr ^ frame_bits[k];
    m_ov  = 1'b1;
    m_sel = 0;
  endtask

  // One clock: check in_ready against the model, advance the model across the
  // edge, then check the registered outputs.
  task automatic cycle(output bit accepted);
    bit exp_rdy, acc, bacc, b, r, done;
    #1;
    exp_rdy = !((m_sel == FRAME - 1) && m_ov && !out_ready);
    if (m_known && !rst) begin
      chk("in_ready_lsb", {7'd0, rdy_l}, {7'd0, exp_rdy});
      chk("in_ready_msb", {7'd0, rdy_m}, {7'd0, exp_rdy});
    end
    acc  = in_valid && exp_rdy;
    bacc = m_ov && out_ready;
    b    = in_bit;
    r    = rst;
    done = 1'b0;
    @(posedge clk);
    if (r) begin
      m_sel   = 0;
      m_ov    = 1'b0;
      m_lsb   = 8'h00;
      m_msb   = 8'h00;
      m_perr  = 1'b0;
      m_known = 1'b1;
      acc     = 1'b0;
    end else begin
      if (acc) begin
        frame_bits[m_sel] = b;
        if (m_sel == FRAME - 1) begin
          publish();
          done = 1'b1;
        end else begin
          m_sel++;
        end
      end
      if (!done && bacc) m_ov = 1'b0;
    end
    accepted = acc;
    #1;
    if (m_known) begin
      chk("sel_lsb", 8'(sel_l), 8'(m_sel));
      chk("sel_msb", 8'(sel_m), 8'(m_sel));
      chk("out_valid_lsb", {7'd0, ov_l}, {7'd0, m_ov});
      chk("out_valid_msb", {7'd0, ov_m}, {7'd0, m_ov});
      chk("out_data_lsb", od_l, m_lsb);
      chk("out_data_msb", od_m, m_msb);
`ifdef DEMUX8_PARITY_EN
      if (m_ov) begin
        chk("parity_err_lsb", {7'd0, pe_l}, {7'd0, m_perr});
        chk("parity_err_msb", {7'd0, pe_m}, {7'd0, m_perr});
      end
`endif
    end
  endtask

  task automatic send_bit(input bit b);
    bit a;
    int waited;
    in_valid = 1'b1;
    in_bit   = b;
    waited   = 0;
    a        = 1'b0;
    while (!a && waited < 40) begin
      cycle(a);
      waited++;
    end
    if (!a) begin
      n_total++;
      $error("FAIL bit_timeout: observed not accepted after %0d cycles required accepted", waited);
    end
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_bit = 1'($urandom);
      cycle(a);
    end
  endtask

  // Stream byte b LSB-first; gaps inserts an idle cycle before every bit.
  task automatic send_frame(input logic [7:0] b, input bit gaps, input bit bad_par);
    bit a;
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom);
        cycle(a);
      end
      send_bit(b[k]);
    end
`ifdef DEMUX8_PARITY_EN
    send_bit((^b) ^ bad_par);
`else
    if (bad_par) send_bit(1'b0);
`endif
    in_valid = 1'b0;
  endtask

  initial begin
    bit a;
    logic [7:0] c3;
    m_known  = 1'b0;
    m_sel    = 0;
    m_ov     = 1'b0;
    m_lsb    = 8'h00;
    m_msb    = 8'h00;
    m_perr   = 1'b0;
    c3       = 8'hC3;

    // Reset with random inputs, then idle.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'($urandom);
      in_bit    = 1'($urandom);
      out_ready = 1'($urandom);
      cycle(a);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    idle(2);
    chk("reset_sel", 8'(sel_l), 8'h00);
    chk("reset_out_data", od_l, 8'h00);
    chk("reset_out_valid", {7'd0, ov_l}, 8'h00);

    // Back-to-back A5, then 01 (reversed order gives 80).
    send_frame(8'hA5, 1'b0, 1'b0);
    chk("a5_lsb", od_l, 8'hA5);
    chk("a5_msb", od_m, 8'hA5);
    chk("a5_valid", {7'd0, ov_l}, 8'h01);
    idle(1);
    chk("a5_drained", {7'd0, ov_l}, 8'h00);
    send_frame(8'h01, 1'b0, 1'b0);
    chk("b01_lsb", od_l, 8'h01);
    chk("b01_msb", od_m, 8'h80);
    idle(1);

    // Backpressure: 3C held while C3 assembles and stalls on its last bit.
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < FRAME - 1; k++) send_bit(c3[k]);
`ifdef DEMUX8_PARITY_EN
    in_bit = ^c3;
`else
    in_bit = c3[7];
`endif
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle(a);
    chk("stall_in_ready", {7'd0, rdy_l}, 8'h00);
    chk("stall_sel", 8'(sel_l), 8'(FRAME - 1));
    chk("stall_hold", od_l, 8'h3C);
    out_ready = 1'b1;
    cycle(a);
    chk("swap_data", od_l, 8'hC3);
    chk("swap_valid", {7'd0, ov_l}, 8'h01);
    idle(2);

    // Gapped input.
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("gap_lsb", od_l, 8'h5A);
    chk("gap_msb", od_m, 8'h5A);
    idle(1);

    // Reset mid-frame with a byte pending.
    out_ready = 1'b0;
    send_frame(8'h96, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_bit(1'b0);
    rst      = 1'b1;
    in_valid = 1'($urandom);
    in_bit   = 1'($urandom);
    cycle(a);
    rst = 1'b0;
    chk("midrst_sel", 8'(sel_l), 8'h00);
    chk("midrst_valid", {7'd0, ov_l}, 8'h00);
    out_ready = 1'b1;
    send_frame(8'hFF, 1'b0, 1'b0);
    chk("ff_lsb", od_l, 8'hFF);
    chk("ff_msb", od_m, 8'hFF);
    idle(1);

`ifdef DEMUX8_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b0);
    chk("par_ok_err", {7'd0, pe_l}, 8'h00);
    chk("par_ok_data", od_l, 8'h07);
    idle(1);
    send_frame(8'h07, 1'b0, 1'b1);
    chk("par_bad_err", {7'd0, pe_l}, 8'h01);
    chk("par_bad_data", od_l, 8'h07);
    idle(1);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle(a);
    end
    rst = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
